// File: rtl/mem_resp_pkg.sv
// Shared types and byte-lane helpers for the memory refill responder.
// Address-mode encodings normally come from def.sv; the guarded fallbacks below keep this slice standalone.
`ifndef DATA_ADDR_MODE_B
`define DATA_ADDR_MODE_B  3'b000
`endif
`ifndef DATA_ADDR_MODE_H
`define DATA_ADDR_MODE_H  3'b001
`endif
`ifndef DATA_ADDR_MODE_W
`define DATA_ADDR_MODE_W  3'b010
`endif
`ifndef DATA_ADDR_MODE_BU
`define DATA_ADDR_MODE_BU 3'b100
`endif
`ifndef DATA_ADDR_MODE_HU
`define DATA_ADDR_MODE_HU 3'b101
`endif

package mem_resp_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

    function automatic logic [3:0] lane_mask(input logic [2:0] mode, input logic [1:0] a);
        logic [3:0] m;
        case (mode)
            `DATA_ADDR_MODE_B, `DATA_ADDR_MODE_BU: m = 4'b0001 << a;
            `DATA_ADDR_MODE_H, `DATA_ADDR_MODE_HU: m = a[1] ? 4'b1100 : 4'b0011;
            default:                               m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic addr_aligned(input logic [2:0] mode, input logic [1:0] a);
        logic ok;
        case (mode)
            `DATA_ADDR_MODE_B, `DATA_ADDR_MODE_BU: ok = 1'b1;
            `DATA_ADDR_MODE_H, `DATA_ADDR_MODE_HU: ok = (a[0] == 1'b0);
            default:                               ok = (a == 2'b00);
        endcase
        return ok;
    endfunction

    // Write data arrives LSB-aligned; replicate it so every candidate lane sees the right bytes.
    function automatic logic [31:0] wdata_align(input logic [2:0] mode, input logic [31:0] d);
        logic [31:0] r;
        case (mode)
            `DATA_ADDR_MODE_B, `DATA_ADDR_MODE_BU: r = {4{d[7:0]}};
            `DATA_ADDR_MODE_H, `DATA_ADDR_MODE_HU: r = {2{d[15:0]}};
            default:                               r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_byte_array.sv
// Word-organised storage built from four byte lanes with per-lane write enables and a registered read port.
module mem_byte_array #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    we,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [7:0] lane_q [DEPTH];
        logic [7:0] rd_q;

        always_ff @(posedge clk) begin
            if (we[g]) begin
                lane_q[addr] <= wdata[8*g +: 8];
            end
            rd_q <= lane_q[addr];
        end

        assign rdata[8*g +: 8] = rd_q;
    end

endmodule

// File: rtl/mem_refill_responder.sv
// Memory-side responder: fixed-latency refill reads and write-through writes over valid/ready channels.
// Define MEM_RESP_STATS_EN to add saturating read/write/error counters.
module mem_refill_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MEM_DEPTH_WORDS = 1024,
    parameter int LATENCY         = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_addr_mode,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  busy
`ifdef MEM_RESP_STATS_EN
    ,
    output logic [31:0]           stat_reads,
    output logic [31:0]           stat_writes,
    output logic [31:0]           stat_errs
`endif
);

    localparam int MEM_AW = (MEM_DEPTH_WORDS > 1) ? $clog2(MEM_DEPTH_WORDS) : 1;
    localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [ADDR_WIDTH-1:0] DEPTH_LIMIT = ADDR_WIDTH'(MEM_DEPTH_WORDS);

    state_t state, state_next;

    logic [CNT_W-1:0]      cnt;
    logic                  lat_we;
    logic [2:0]            lat_mode;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;

    logic                  accept;
    logic [ADDR_WIDTH-3:0] sel_idx;
    logic                  in_range;
    logic                  acc_err;
    logic [3:0]            mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Handshake: a transfer happens on a rising clk edge where both valid and ready are high.
    // req_ready comes from registered state only, so a request can never be taken in the RESP->IDLE cycle.
    assign req_ready  = rst_n && (state == IDLE);
    assign accept     = (state == IDLE) && req_valid;
    assign resp_valid = (state == RESP);
    assign busy       = (state != IDLE);

    // The read port tracks the incoming address while idle so the word is ready by the ACCESS cycle,
    // even when LATENCY is 1.
    assign sel_idx  = (state == IDLE) ? req_addr[ADDR_WIDTH-1:2] : lat_addr[ADDR_WIDTH-1:2];
    assign in_range = ({2'b00, sel_idx} < DEPTH_LIMIT);
    assign acc_err  = !in_range || !addr_aligned(lat_mode, lat_addr[1:0]);
    assign mem_we   = (state == ACCESS && lat_we && !acc_err) ? lane_mask(lat_mode, lat_addr[1:0]) : 4'b0000;

    mem_byte_array #(
        .DEPTH (MEM_DEPTH_WORDS),
        .AW    (MEM_AW)
    ) u_mem (
        .clk   (clk),
        .addr  (sel_idx[MEM_AW-1:0]),
        .we    (mem_we),
        .wdata (wdata_align(lat_mode, lat_wdata)),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (LATENCY == 1) ? ACCESS : WAIT;
                end
            end
            WAIT: begin
                // Leaving as cnt reaches zero puts resp_valid exactly LATENCY cycles after accept.
                if (cnt <= CNT_W'(1)) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: state_next = RESP;
            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            lat_we     <= 1'b0;
            lat_mode   <= '0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt       <= CNT_W'(LATENCY - 1);
                        lat_we    <= req_we;
                        lat_mode  <= req_addr_mode;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                    end
                end
                WAIT: cnt <= cnt - CNT_W'(1);
                ACCESS: begin
                    resp_rdata <= (lat_we || acc_err) ? '0 : mem_rdata;
                    resp_err   <= acc_err;
                end
                default: ;
            endcase
        end
    end

`ifdef MEM_RESP_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_reads  <= '0;
            stat_writes <= '0;
            stat_errs   <= '0;
        end else if (state == ACCESS) begin
            if (lat_we && stat_writes != '1) begin
                stat_writes <= stat_writes + 32'd1;
            end
            if (!lat_we && stat_reads != '1) begin
                stat_reads <= stat_reads + 32'd1;
            end
            if (acc_err && stat_errs != '1) begin
                stat_errs <= stat_errs + 32'd1;
            end
        end
    end
`endif

endmodule
